counter_seg_display: RTL
========================

Name: counter_seg_display

Overview:
- Downstream consumer of the 4-bit up/down counter; takes its count `q` and carry/borrow `co`.
- Keeps a 4-bit wrap count by counting `co` events, giving an 8-bit extended value.
- Drives a two-digit multiplexed 7-segment display: low digit = counter `q`, high digit = wrap count, both shown as hex.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 4: clocks per digit slot of the scan prescaler; must be ≥2 (compile-time check, elaboration error otherwise).
- SEG_ACTIVE_LOW, 1: 1 = segment lit when bit is 0; 0 = lit when 1.

Ports:
- clk  in  1  system clock, rising edge.
- mr_n  in  1  asynchronous active-low reset.
- q  in  4  counter value.
- co  in  1  counter carry/borrow output, level.
- up_down  in  1  counter direction; 0 = up, 1 = down; sampled together with co.
- clr  in  1  synchronous clear of the wrap count; tie to the counter's clear/load strobe.
- wrap  out  4  current wrap count.
- an  out  2  one-hot digit enable, active-high; an[0] = low digit, an[1] = high digit.
- seg  out  7  segments {g,f,e,d,c,b,a}; polarity set by SEG_ACTIVE_LOW.

Behaviour:
- Reset (mr_n=0, async):
  - q_r=0, co_d=0, wrap=0, pre=0, sel=0, valid=0.
  - an=2'b00; seg=all-off (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
- Input capture: q_r <= q every cycle (1-cycle latency to the display).
- co edge detect: co_d <= co; co_rise = co & ~co_d.
  - A co level held for N cycles counts once.
  - co already high at reset release counts once on the first clock.
- Wrap count, priority order:
  1. clr=1: wrap <= 0; a simultaneous co_rise is discarded.
  2. co_rise with up_down=0: wrap <= wrap+1 (mod 16; 15→0).
  3. co_rise with up_down=1: wrap <= wrap-1 (mod 16; 0→15).
  4. Otherwise hold.
- wrap output is the register itself: visible the cycle after co_rise.
- Prescaler:
  - pre counts 0..SCAN_DIV-1 and wraps.
  - tick = (pre == SCAN_DIV-1).
  - On tick: sel <= ~sel and valid <= 1.
- Output registers, every cycle:
  - an <= valid ? (sel ? 2'b10 : 2'b01) : 2'b00.
  - seg <= valid ? enc(sel ? wrap : q_r) : off, where enc = standard hex decode, inverted when SEG_ACTIVE_LOW.
  - An and seg always refer to the same digit in the same cycle; no ghosting cycle.
- Scan timing:
  - First tick occurs SCAN_DIV cycles after reset release; sel becomes 1 on that tick.
  - an first goes non-zero one cycle later, on the high digit (2'b10).
  - Each digit is then held SCAN_DIV cycles.
- Digit codes (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Reset mid-scan: all state returns to reset values immediately; outputs go blank asynchronously.

Optional Feature:
- Macro: SEGDISP_BLANK_EN.
- Defined: when the high digit is selected and wrap==0, seg = off while an still = 2'b10 (leading-zero blanking).
- Undefined: the high digit always shows wrap, including "0".
- The low digit is never blanked in either case.

Decomposition:
- Package seg_pkg:
  - SEG_OFF_AH = 7'h00.
  - 16-entry hex→segment constant table (active-high).
  - Digit-select encodings AN_LO = 2'b01, AN_HI = 2'b10.
- Sub-module hex_to_seg7: 4-bit value in, 7-bit active-high segments out, purely combinational. Polarity inversion and blanking stay in the top.

Test Plan:
1. Reset, then release with SCAN_DIV=4, q=4'h1 → an=00 and seg=7F for 4 cycles; then an=10, seg=~3F=40; 4 cycles later an=01, seg=~06=79.
2. up_down=0, single co pulse 1 cycle, then co held 5 cycles → wrap goes 0→1→2; exactly 2 increments.
3. From wrap=0, up_down=1, one co pulse → wrap=15; high-digit seg=~71=0E.
4. From wrap=15, up_down=0, co pulse → wrap=0.
5. clr=1 in the same cycle as co_rise with wrap=5 → wrap=0 next cycle, no increment.
6. Assert mr_n=0 mid-scan while an=01 → an=00 and seg=7F immediately, without waiting for a clock edge. With SEGDISP_BLANK_EN defined and wrap=0, the high slot shows an=10, seg=7F.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the two-digit hex 7-segment display path.
package seg_pkg;
    localparam logic [6:0] SEG_OFF_AH = 7'h00;
    localparam logic [1:0] AN_LO = 2'b01;
    localparam logic [1:0] AN_HI = 2'b10;
    // Active-high gfedcba patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
endpackage

// File: rtl/counter_seg_display_hex_to_seg7.sv
// hex_to_seg7: combinational hex digit to active-high {g,f,e,d,c,b,a} decode.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[val];
endmodule

// File: rtl/counter_seg_display.sv
// counter_seg_display: counts counter co events into a wrap digit and scans q/wrap onto two 7-seg digits.
// Optional SEGDISP_BLANK_EN blanks the high digit when wrap is zero.
module counter_seg_display
    import seg_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       mr_n,
    input  logic [3:0] q,
    input  logic       co,
    input  logic       up_down,
    input  logic       clr,
    output logic [3:0] wrap,
    output logic [1:0] an,
    output logic [6:0] seg
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF_AH : SEG_OFF_AH;

    generate
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("SCAN_DIV must be >= 2");
        end
    endgenerate

    logic [3:0]    q_r;
    logic          co_d;
    logic [PW-1:0] pre;
    logic          sel;
    logic          valid;
    logic          co_rise;
    logic          tick;
    logic          blank;
    logic [3:0]    wrap_nx;
    logic [6:0]    seg_ah;
    logic [6:0]    seg_nx;
    logic [1:0]    an_nx;

    hex_to_seg7 u_dec (
        .val (sel ? wrap : q_r),
        .seg (seg_ah)
    );

    always_comb begin
        co_rise = co & ~co_d;
        tick    = pre == PW'(SCAN_DIV - 1);
        // clr wins over a coincident co edge so a load never leaves a stale wrap
        wrap_nx = clr ? 4'd0 : co_rise ? (up_down ? wrap - 4'd1 : wrap + 4'd1) : wrap;
`ifdef SEGDISP_BLANK_EN
        blank   = sel && wrap == 4'd0;
`else
        blank   = 1'b0;
`endif
        an_nx   = valid ? (sel ? AN_HI : AN_LO) : 2'b00;
        seg_nx  = (valid && !blank) ? (SEG_ACTIVE_LOW ? ~seg_ah : seg_ah) : SEG_OFF;
    end

    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            q_r   <= 4'd0;
            co_d  <= 1'b0;
            wrap  <= 4'd0;
            pre   <= '0;
            sel   <= 1'b0;
            valid <= 1'b0;
            an    <= 2'b00;
            seg   <= SEG_OFF;
        end else begin
            q_r   <= q;
            co_d  <= co;
            wrap  <= wrap_nx;
            pre   <= tick ? '0 : pre + PW'(1);
            sel   <= tick ? ~sel : sel;
            valid <= valid | tick;
            an    <= an_nx;
            seg   <= seg_nx;
        end
    end
endmodule
